// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu_issue slice: ALU opcodes, SREG bit
// positions, issue FSM states and the instruction classifier.
package alu_issue_pkg;

    // ALU operation codes carried in instr[13:10].
    localparam logic [3:0] OP_CPC  = 4'b0001;
    localparam logic [3:0] OP_SBC  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_CPSE = 4'b0100;
    localparam logic [3:0] OP_CP   = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_ADC  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_EOR  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1010;
    localparam logic [3:0] OP_MOV  = 4'b1011;

    // SREG bit indices.
    localparam int SREG_H = 5;
    localparam int SREG_S = 4;
    localparam int SREG_V = 3;
    localparam int SREG_N = 2;
    localparam int SREG_Z = 1;
    localparam int SREG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CLS_NOP     = 2'b00,
        CLS_ALU     = 2'b01,
        CLS_ILLEGAL = 2'b10
    } instr_class_t;

    // Sort an instruction word into NOP, a two-register ALU op, or illegal.
    function automatic instr_class_t classify(input logic [15:0] instr);
        instr_class_t cls;
        if (instr == 16'h0000) begin
            cls = CLS_NOP;
        end else if ((instr[15:12] == 4'b0000) && (instr[11:10] != 2'b00)) begin
            cls = CLS_ALU;
        end else if ((instr[15:12] == 4'b0001) || (instr[15:12] == 4'b0010)) begin
            cls = CLS_ALU;
        end else begin
            cls = CLS_ILLEGAL;
        end
        return cls;
    endfunction

    // Compares (CP, CPC, CPSE) only update flags; everything else writes Rd.
    function automatic logic op_writes_rd(input logic [3:0] op);
        logic wr;
        case (op)
            OP_CP, OP_CPC, OP_CPSE: wr = 1'b0;
            default:                wr = 1'b1;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/alu_issue_register_file.sv
// 32x8 register file.
// Ports: clk/rst_n (async active-low clear of all entries), two combinational
// read ports (a, b), a combinational debug read port, one synchronous write port.
module register_file (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rd_addr_a,
    output logic [7:0] rd_data_a,
    input  logic [4:0] rd_addr_b,
    output logic [7:0] rd_data_b,
    input  logic [4:0] dbg_addr,
    output logic [7:0] dbg_data,
    input  logic       we,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data
);

    logic [7:0] mem_r [32];

    // Storage array: cleared on reset, single write port otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem_r[rd_addr_a];
    assign rd_data_b = mem_r[rd_addr_b];
    assign dbg_data  = mem_r[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue / write-back stage around an external 8-bit AVR ALU.
// Accepts one two-register instruction at a time (IDLE -> EXEC [-> WAIT]),
// presents registered operands to the ALU, writes result/flags back to the
// register file and SREG, and implements the CPSE one-word skip.
// Ports: i_clk, i_reset_n (async active-low); i_instr/i_instr_valid/o_instr_ready
// handshake; o_illegal/o_skipped status pulses; o_alu_* to the ALU and
// i_alu_result/i_alu_flags back; o_sreg; debug port i_dbg_* / o_dbg_data.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_instr,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    output logic        o_illegal,
    output logic        o_skipped,
    output logic [3:0]  o_alu_operation,
    output logic [7:0]  o_alu_op1,
    output logic [7:0]  o_alu_op2,
    output logic [5:0]  o_alu_flags,
    input  logic [7:0]  i_alu_result,
    input  logic [5:0]  i_alu_flags,
    output logic [7:0]  o_sreg,
    input  logic [4:0]  i_dbg_addr,
    output logic [7:0]  o_dbg_data,
    input  logic        i_dbg_we,
    input  logic [7:0]  i_dbg_wdata
);

    state_t       state_r, state_next_s;
    logic [15:0]  instr_r;
    logic         ready_r, illegal_r, skipped_r, skip_pending_r;
    logic [3:0]   operation_r;
    logic [7:0]   op1_r, op2_r;
    logic [5:0]   sreg_r;

    logic         accept_s, wb_s, wb_alu_s, dbg_we_s;
    logic [4:0]   acc_rd_s, acc_rr_s, rd_addr_s;
    logic [7:0]   rf_rd_s, rf_rr_s, op1_in_s, op2_in_s;
    logic         rf_we_s;
    logic [4:0]   rf_waddr_s;
    logic [7:0]   rf_wdata_s;
    instr_class_t class_s;

    assign accept_s = (state_r == ST_IDLE) && i_instr_valid && ready_r;
    assign wb_s     = (state_r == ST_WAIT) || ((state_r == ST_EXEC) && (ALU_LATENCY == 0));
    assign dbg_we_s = i_dbg_we && (state_r == ST_IDLE);

    assign acc_rd_s  = i_instr[8:4];
    assign acc_rr_s  = {i_instr[9], i_instr[3:0]};
    assign rd_addr_s = instr_r[8:4];
    assign class_s   = classify(instr_r);
    assign wb_alu_s  = wb_s && (class_s == CLS_ALU) && !skip_pending_r;

    // A debug write landing on the accept edge must be seen by EXEC, so bypass it.
    assign op1_in_s = (dbg_we_s && (i_dbg_addr == acc_rd_s)) ? i_dbg_wdata : rf_rd_s;
    assign op2_in_s = (dbg_we_s && (i_dbg_addr == acc_rr_s)) ? i_dbg_wdata : rf_rr_s;

    // Debug writes only occur in IDLE and write-back never does, so they share the port.
    assign rf_we_s    = dbg_we_s || (wb_alu_s && op_writes_rd(operation_r));
    assign rf_waddr_s = dbg_we_s ? i_dbg_addr  : rd_addr_s;
    assign rf_wdata_s = dbg_we_s ? i_dbg_wdata : i_alu_result;

    register_file u_rf (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .rd_addr_a (acc_rd_s),
        .rd_data_a (rf_rd_s),
        .rd_addr_b (acc_rr_s),
        .rd_data_b (rf_rr_s),
        .dbg_addr  (i_dbg_addr),
        .dbg_data  (o_dbg_data),
        .we        (rf_we_s),
        .wr_addr   (rf_waddr_s),
        .wr_data   (rf_wdata_s)
    );

    // Issue FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (ALU_LATENCY == 0) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_WAIT: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state, handshake and status pulse registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r   <= ST_IDLE;
            ready_r   <= 1'b0;
            illegal_r <= 1'b0;
            skipped_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            ready_r   <= (state_next_s == ST_IDLE);
            illegal_r <= wb_s && !skip_pending_r && (class_s == CLS_ILLEGAL);
            skipped_r <= wb_s && skip_pending_r;
        end
    end

    // Instruction and operand capture at accept; held through write-back.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            instr_r     <= 16'h0000;
            operation_r <= 4'h0;
            op1_r       <= 8'h00;
            op2_r       <= 8'h00;
        end else if (accept_s) begin
            instr_r     <= i_instr;
            operation_r <= i_instr[13:10];
            op1_r       <= op1_in_s;
            op2_r       <= op2_in_s;
        end
    end

    // SREG flag write-back and CPSE skip tracking.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sreg_r         <= 6'h00;
            skip_pending_r <= 1'b0;
        end else if (wb_s) begin
            if (wb_alu_s) begin
                sreg_r <= i_alu_flags;
            end
            if (skip_pending_r) begin
                skip_pending_r <= 1'b0;
            end else if (wb_alu_s && (operation_r == OP_CPSE) && (op1_r == op2_r)) begin
                skip_pending_r <= 1'b1;
            end
        end
    end

    assign o_instr_ready   = ready_r;
    assign o_illegal       = illegal_r;
    assign o_skipped       = skipped_r;
    assign o_alu_operation = operation_r;
    assign o_alu_op1       = op1_r;
    assign o_alu_op2       = op2_r;
    assign o_alu_flags     = sreg_r;
    assign o_sreg          = {2'b00, sreg_r};

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural one-cycle AVR ALU.
module tb_alu_issue;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [15:0] i_instr;
    logic        i_instr_valid;
    logic        o_instr_ready, o_illegal, o_skipped;
    logic [3:0]  o_alu_operation;
    logic [7:0]  o_alu_op1, o_alu_op2;
    logic [5:0]  o_alu_flags;
    logic [7:0]  i_alu_result;
    logic [5:0]  i_alu_flags;
    logic [7:0]  o_sreg;
    logic [4:0]  i_dbg_addr;
    logic [7:0]  o_dbg_data;
    logic        i_dbg_we;
    logic [7:0]  i_dbg_wdata;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    alu_issue #(.ALU_LATENCY(1)) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_instr         (i_instr),
        .i_instr_valid   (i_instr_valid),
        .o_instr_ready   (o_instr_ready),
        .o_illegal       (o_illegal),
        .o_skipped       (o_skipped),
        .o_alu_operation (o_alu_operation),
        .o_alu_op1       (o_alu_op1),
        .o_alu_op2       (o_alu_op2),
        .o_alu_flags     (o_alu_flags),
        .i_alu_result    (i_alu_result),
        .i_alu_flags     (i_alu_flags),
        .o_sreg          (o_sreg),
        .i_dbg_addr      (i_dbg_addr),
        .o_dbg_data      (o_dbg_data),
        .i_dbg_we        (i_dbg_we),
        .i_dbg_wdata     (i_dbg_wdata)
    );

    // Behavioural AVR ALU: returns {result, H,S,V,N,Z,C}.
    function automatic logic [13:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic [5:0] f);
        logic [7:0] r;
        logic h, s, v, n, z, c, cin;
        h = f[5]; s = f[4]; v = f[3]; n = f[2]; z = f[1]; c = f[0];
        r = a;
        case (op)
            4'b0011, 4'b0111: begin
                cin = (op == 4'b0111) ? f[0] : 1'b0;
                r = a + b + {7'd0, cin};
                h = (a[3] & b[3]) | (b[3] & ~r[3]) | (~r[3] & a[3]);
                v = (a[7] & b[7] & ~r[7]) | (~a[7] & ~b[7] & r[7]);
                c = (a[7] & b[7]) | (b[7] & ~r[7]) | (~r[7] & a[7]);
                n = r[7]; z = (r == 8'h00); s = n ^ v;
            end
            4'b0110, 4'b0101, 4'b0010, 4'b0001: begin
                cin = (op == 4'b0010 || op == 4'b0001) ? f[0] : 1'b0;
                r = a - b - {7'd0, cin};
                h = (~a[3] & b[3]) | (b[3] & r[3]) | (r[3] & ~a[3]);
                v = (a[7] & ~b[7] & ~r[7]) | (~a[7] & b[7] & r[7]);
                c = (~a[7] & b[7]) | (b[7] & r[7]) | (r[7] & ~a[7]);
                n = r[7];
                z = (r == 8'h00) & ((op == 4'b0010 || op == 4'b0001) ? f[1] : 1'b1);
                s = n ^ v;
            end
            4'b1000, 4'b1001, 4'b1010: begin
                r = (op == 4'b1000) ? (a & b) : (op == 4'b1001) ? (a ^ b) : (a | b);
                v = 1'b0; n = r[7]; z = (r == 8'h00); s = n ^ v;
            end
            4'b1011: r = b;
            default: r = a;
        endcase
        return {r, h, s, v, n, z, c};
    endfunction

    logic [13:0] alu_q;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) alu_q <= 14'h0;
        else            alu_q <= alu_model(o_alu_operation, o_alu_op1, o_alu_op2, o_alu_flags);
    end
    assign i_alu_result = alu_q[13:6];
    assign i_alu_flags  = alu_q[5:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [7:0] d);
        i_dbg_addr = a;
        #1;
        d = o_dbg_data;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd_reg(a, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_instr_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check("ready_wait", 32'(o_instr_ready), 32'd1);
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge i_clk);
        i_dbg_we = 1'b1; i_dbg_addr = a; i_dbg_wdata = d;
        @(posedge i_clk);
        #1;
        i_dbg_we = 1'b0;
    endtask

    // Issue one instruction and check ready/illegal/skipped over four samples.
    task automatic issue(input logic [15:0] ins, input string tag,
                         input logic exp_ill, input logic exp_skp);
        logic [3:0] rdy_v, ill_v, skp_v;
        wait_ready();
        i_instr = ins;
        i_instr_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_instr_valid = 1'b0;
        i_dbg_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            rdy_v[i] = o_instr_ready;
            ill_v[i] = o_illegal;
            skp_v[i] = o_skipped;
        end
        check({tag, "_ready"}, 32'(rdy_v), 32'(4'b1100));
        check({tag, "_illegal"}, 32'(ill_v), 32'({1'b0, exp_ill, 2'b00}));
        check({tag, "_skipped"}, 32'(skp_v), 32'({1'b0, exp_skp, 2'b00}));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] rdy_t;
        logic [7:0] r1_t;
        i_reset_n = 1'b0; i_instr = 16'h0000; i_instr_valid = 1'b0;
        i_dbg_addr = 5'd0; i_dbg_we = 1'b0; i_dbg_wdata = 8'h00;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        #1;
        check("rst_ready", 32'(o_instr_ready), 32'd0);
        check("rst_sreg", 32'(o_sreg), 32'h00);
        check("rst_pulses", 32'({o_illegal, o_skipped}), 32'd0);
        check("rst_alu", 32'({o_alu_operation, o_alu_op1, o_alu_op2}), 32'd0);
        check_reg("rst_r31", 5'd31, 8'h00);
        @(negedge i_clk);
        check("rst_ready_rise", 32'(o_instr_ready), 32'd1);

        // ADD R1,R2: 0x7F + 0x01
        dbg_write(5'd1, 8'h7F); dbg_write(5'd2, 8'h01);
        issue(16'h0C12, "add", 1'b0, 1'b0);
        check_reg("add_r1", 5'd1, 8'h80);
        check("add_sreg", 32'(o_sreg), 32'h2C);

        // CP R1,R2: equal operands
        dbg_write(5'd1, 8'h05); dbg_write(5'd2, 8'h05);
        issue(16'h1412, "cp", 1'b0, 1'b0);
        check_reg("cp_r1", 5'd1, 8'h05);
        check("cp_sreg", 32'(o_sreg), 32'h02);

        // CPSE R3,R4 equal -> skip MOV R5,R3, then MOV R6,R3 executes
        dbg_write(5'd3, 8'h10); dbg_write(5'd4, 8'h10);
        issue(16'h1034, "cpse", 1'b0, 1'b0);
        issue(16'h2C53, "skip", 1'b0, 1'b1);
        issue(16'h2C63, "mov", 1'b0, 1'b0);
        check_reg("cpse_r5", 5'd5, 8'h00);
        check_reg("cpse_r6", 5'd6, 8'h10);
        check("cpse_sreg", 32'(o_sreg), 32'h02);

        // CPSE unequal -> following MOV R5,R3 executes
        dbg_write(5'd4, 8'h11);
        issue(16'h1034, "cpse_ne", 1'b0, 1'b0);
        issue(16'h2C53, "mov_ne", 1'b0, 1'b0);
        check_reg("cpse_ne_r5", 5'd5, 8'h10);

        // SUB R7,R8: 0x10 - 0x20
        dbg_write(5'd7, 8'h10); dbg_write(5'd8, 8'h20);
        issue(16'h1878, "sub", 1'b0, 1'b0);
        check_reg("sub_r7", 5'd7, 8'hF0);
        check("sub_sreg", 32'(o_sreg), 32'h15);

        // Illegal word and NOP leave state alone
        dbg_write(5'd0, 8'h5A);
        issue(16'h9508, "illegal", 1'b1, 1'b0);
        check_reg("ill_r0", 5'd0, 8'h5A);
        check("ill_sreg", 32'(o_sreg), 32'h15);
        issue(16'h0000, "nop", 1'b0, 1'b0);
        check("nop_sreg", 32'(o_sreg), 32'h15);

        // Debug write to R2 on the accept edge is seen by the ADD
        dbg_write(5'd1, 8'h01); dbg_write(5'd2, 8'h09);
        wait_ready();
        i_dbg_we = 1'b1; i_dbg_addr = 5'd2; i_dbg_wdata = 8'h03;
        issue(16'h0C12, "dbg_acc", 1'b0, 1'b0);
        check_reg("dbg_acc_r1", 5'd1, 8'h04);
        check_reg("dbg_acc_r2", 5'd2, 8'h03);

        // Throughput: valid held high for three ADD R1,R2 (R1=1, R2=1)
        dbg_write(5'd1, 8'h01); dbg_write(5'd2, 8'h01);
        wait_ready();
        @(negedge i_clk);
        i_dbg_addr = 5'd1;
        i_instr = 16'h0C12;
        i_instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            rdy_t[i] = o_instr_ready;
            r1_t = o_dbg_data;
            check($sformatf("tput_r1_%0d", i), 32'(r1_t),
                  32'(8'd1 + 8'(i / 3)));
            if (i == 7) i_instr_valid = 1'b0;
            @(negedge i_clk);
        end
        check("tput_ready", 32'(rdy_t), 32'(10'b1001001001));

        // Reset asserted during EXEC of an ADD aborts it
        dbg_write(5'd1, 8'h11); dbg_write(5'd2, 8'h22);
        wait_ready();
        i_instr = 16'h0C12;
        i_instr_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_instr_valid = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(o_instr_ready), 32'd0);
        check("mid_rst_sreg", 32'(o_sreg), 32'h00);
        check("mid_rst_op1", 32'(o_alu_op1), 32'h00);
        check_reg("mid_rst_r1", 5'd1, 8'h00);
        check_reg("mid_rst_r2", 5'd2, 8'h00);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        #1;
        check("rel_ready_low", 32'(o_instr_ready), 32'd0);
        repeat (2) @(negedge i_clk);
        check("rel_ready_high", 32'(o_instr_ready), 32'd1);
        check_reg("rel_r1", 5'd1, 8'h00);
        check("rel_sreg", 32'(o_sreg), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
